lane_word_packer: RTL and testbench

- Sits upstream of the 128-bit single-bit-per-lane instance-array stage.
- Collects successive LANES-bit lane samples, one per accepted beat, and packs BEATS of them into one wide word that drives that stage's 128-bit input bus.
- Valid/ready on both sides; output is double-buffered so filling continues while a finished word waits.
- Flush input closes a partial word early, with zero padding.

---
 rtl/lane_pack_pkg.sv | 16 +
 rtl/lane_word_packer_out_reg.sv | 33 +++
 rtl/lane_word_packer.sv | 105 ++++++++++
 tb/tb_lane_word_packer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lane_pack_pkg.sv
// Shared widths, state type and word type for the lane word packer.
// Defaults match the 128-bit single-bit-per-lane array stage.
package lane_pack_pkg;
  localparam int LANES   = 8;
  localparam int BEATS   = 16;
  localparam int WORD_W  = LANES * BEATS;
  localparam int CNT_W   = $clog2(BEATS);
  localparam int BEATS_W = $clog2(BEATS + 1);

  typedef enum logic {
    FILL,
    HOLD
  } pack_state_e;

  typedef logic [WORD_W-1:0] packed_word_t;
endpackage

// File: rtl/lane_word_packer_out_reg.sv
// Valid/ready holding register for finished words.
// free is high when a word may load this cycle.
module lane_out_reg #(
  parameter int W  = 128,
  parameter int BW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  word,
  input  logic [BW-1:0] beats,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_word,
  output logic [BW-1:0] out_beats,
  output logic          free
);
  assign free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_beats <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_word  <= word;
      out_beats <= beats;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/lane_word_packer.sv
// Packs BEATS lane samples into one wide word, with flush
// to close a partial word early and a double-buffered output.
module lane_word_packer
  import lane_pack_pkg::*;
#(
  parameter int LANES = lane_pack_pkg::LANES,
  parameter int BEATS = lane_pack_pkg::BEATS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_lanes,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*BEATS-1:0]   out_word,
  output logic [$clog2(BEATS+1)-1:0] out_beats
);
  localparam int W  = LANES * BEATS;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BW = $clog2(BEATS + 1);

  pack_state_e   state, state_nx;
  logic [W-1:0]  acc, merged, ld_word;
  logic [CW-1:0] cnt;
  logic [BW-1:0] hold_beats, fill_beats, ld_beats;
  logic          accept, last, close, free, load;

  assign in_ready = (state == FILL) && !rst;
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == CW'(BEATS - 1));
  assign close    = (state == FILL) &&
                    ((accept && last) ||
                     (flush && (cnt != '0 || accept)));
  assign fill_beats = BW'(cnt) + BW'(accept);

  always_comb begin
    merged = acc;
    if (accept) merged[cnt*LANES +: LANES] = in_lanes;
  end

  // FILL loads the merged word straight through; HOLD drains acc.
  always_comb begin
    load     = 1'b0;
    ld_word  = merged;
    ld_beats = fill_beats;
    state_nx = state;
    unique case (state)
      FILL: begin
        if (close && free) load = 1'b1;
        else if (close)    state_nx = HOLD;
      end
      HOLD: begin
        ld_word  = acc;
        ld_beats = hold_beats;
        if (free) begin
          load     = 1'b1;
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      hold_beats <= '0;
    end else if (state == FILL) begin
      if (close) begin
        acc        <= free ? '0 : merged;
        cnt        <= '0;
        hold_beats <= fill_beats;
      end else if (accept) begin
        acc <= merged;
        cnt <= cnt + 1'b1;
      end
    end else if (free) begin
      acc <= '0;
    end
  end

  lane_out_reg #(
    .W  (W),
    .BW (BW)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .word      (ld_word),
    .beats     (ld_beats),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_beats (out_beats),
    .free      (free)
  );
endmodule

// File: tb/tb_lane_word_packer.sv
// Directed and random checks of lane_word_packer against a
// queue-of-beats reference model.
module tb_lane_word_packer;
  localparam int L = 8;
  localparam int B = 16;
  localparam int W = L * B;

  logic         clk = 0;
  logic         rst = 1;
  logic         in_valid = 0;
  logic         in_ready;
  logic [L-1:0] in_lanes = '0;
  logic         flush = 0;
  logic         out_valid;
  logic         out_ready = 0;
  logic [W-1:0] out_word;
  logic [4:0]   out_beats;

  int n_assert = 0;
  int n_fail   = 0;

  logic [L-1:0] cur[$];
  logic [W-1:0] exp_w[$];
  int           exp_b[$];

  lane_word_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_lanes  (in_lanes),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_beats (out_beats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic close_word();
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < cur.size(); k++) w[k*L +: L] = cur[k];
    exp_w.push_back(w);
    exp_b.push_back(cur.size());
    cur.delete();
  endtask

  // One clock: observe handshakes at negedge, update model.
  task automatic tick();
    bit acc, fl;
    @(negedge clk);
    if (rst) begin
      cur.delete();
      exp_w.delete();
      exp_b.delete();
    end else begin
      acc = in_valid && in_ready;
      fl  = flush && in_ready;
      if (out_valid && out_ready) begin
        if (exp_w.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          chk("sb_word", out_word, exp_w.pop_front());
          chk("sb_beats", W'(out_beats), W'(exp_b.pop_front()));
        end
      end
      if (acc) cur.push_back(in_lanes);
      if (cur.size() == B || (fl && cur.size() > 0)) close_word();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [L-1:0] v);
    in_valid = 1;
    in_lanes = v;
    tick();
    in_valid = 0;
  endtask

  logic [W-1:0] w;

  initial begin
    tick();
    chk("rst_valid", W'(out_valid), 0);
    chk("rst_word", out_word, 0);
    chk("rst_beats", W'(out_beats), 0);
    chk("rst_ready", W'(in_ready), 0);
    rst = 0;
    #1;
    chk("ready_after_rst", W'(in_ready), 1);

    out_ready = 1;
    for (int i = 0; i < B; i++) begin
      chk("t1_in_ready", W'(in_ready), 1);
      beat(L'(i));
    end
    chk("t1_valid", W'(out_valid), 1);
    w = 128'h0F0E0D0C0B0A09080706050403020100;
    chk("t1_word", out_word, w);
    chk("t1_beats", W'(out_beats), 16);
    tick();
    chk("t1_drained", W'(out_valid), 0);

    out_ready = 0;
    for (int i = 0; i < B; i++) beat(8'hA5);
    w = {16{8'hA5}};
    chk("t2_w0_valid", W'(out_valid), 1);
    chk("t2_w0_word", out_word, w);
    for (int i = 0; i < B; i++) beat(8'h5A);
    chk("t2_hold_ready", W'(in_ready), 0);
    chk("t2_w0_stable", out_word, w);
    tick();
    chk("t2_hold_ready2", W'(in_ready), 0);
    flush = 1;
    tick();
    flush = 0;
    chk("t4_hold_flush_word", out_word, w);
    chk("t4_hold_flush_ready", W'(in_ready), 0);
    chk("t4_hold_flush_beats", W'(out_beats), 16);
    out_ready = 1;
    tick();
    chk("t2_w1_valid", W'(out_valid), 1);
    chk("t2_w1_word", out_word, {16{8'h5A}});
    chk("t2_ready_back", W'(in_ready), 1);
    tick();
    chk("t2_w1_drained", W'(out_valid), 0);

    beat(8'h11);
    beat(8'h22);
    beat(8'h33);
    flush = 1;
    beat(8'h44);
    flush = 0;
    chk("t3_valid", W'(out_valid), 1);
    chk("t3_beats", W'(out_beats), 4);
    chk("t3_word", out_word, 128'h44332211);
    tick();

    flush = 1;
    tick();
    flush = 0;
    chk("t4_idle_flush", W'(out_valid), 0);
    beat(8'h9C);
    flush = 1;
    tick();
    flush = 0;
    chk("t4_one_beat_beats", W'(out_beats), 1);
    chk("t4_one_beat_word", out_word, 128'h9C);
    tick();

    out_ready = 0;
    for (int i = 0; i < B; i++) beat(8'h77);
    for (int i = 0; i < 5; i++) beat(L'(i + 1));
    chk("t5_pending", W'(out_valid), 1);
    rst = 1;
    #1;
    chk("t5_ready_in_rst", W'(in_ready), 0);
    tick();
    rst = 0;
    chk("t5_valid", W'(out_valid), 0);
    chk("t5_word", out_word, 0);
    for (int i = 0; i < B; i++) beat(8'hFF);
    chk("t5_ones", out_word, {W{1'b1}});
    chk("t5_beats", W'(out_beats), 16);

    for (int i = 0; i < B - 1; i++) beat(L'(8'h30 + i));
    chk("t6_old_held", out_word, {W{1'b1}});
    out_ready = 1;
    beat(8'h3F);
    w = 128'h3F3E3D3C3B3A39383736353433323130;
    chk("t6_no_bubble", W'(out_valid), 1);
    chk("t6_new_word", out_word, w);
    chk("t6_ready", W'(in_ready), 1);
    tick();

    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_lanes  = L'($urandom);
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid  = 0;
    out_ready = 1;
    flush     = 1;
    tick();
    flush = 0;
    for (int i = 0; i < 50; i++) begin
      if (exp_w.size() == 0 && !out_valid) break;
      tick();
    end
    chk("drain_queue_empty", W'(exp_w.size()), 0);
    chk("drain_valid_low", W'(out_valid), 0);
    chk("drain_partial_empty", W'(cur.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
